match_ctrl: RTL and testbench
=============================

MATCH_CTRL -- requirements
Module: match_ctrl

Interface
REQ-001 Parameter WIN_SCORE, default 4, points that end a match (range 1..15).
REQ-002 Parameter SERVE_FRAMES, default 60, frame ticks between serve arm and ball release (range 1..255).
REQ-003 clk  input  1  single system clock; every register is clocked on its rising edge.
REQ-004 rst  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-005 start  input  1  level from the debounced start button; only its rising edge acts.
REQ-006 frame_tick  input  1  one-cycle pulse once per video frame.
REQ-007 ball_out_l  input  1  level; ball has crossed the left goal line, so player 2 scores.
REQ-008 ball_out_r  input  1  level; ball has crossed the right goal line, so player 1 scores.
REQ-009 p1_win  output  1  one-cycle point pulse to the score block for player 1.
REQ-010 p2_win  output  1  one-cycle point pulse to the score block for player 2.
REQ-011 score_rst  output  1  active-high clear to the score block.
REQ-012 ball_reset  output  1  holds the ball at centre court.
REQ-013 ball_en  output  1  enables ball motion.
REQ-014 serve_dir  output  1  serve direction: 0 = toward player 1 (left), 1 = toward player 2 (right).
REQ-015 game_over  output  1  match finished.
REQ-016 state_o  output  3  current state encoding, for debug display.

Function
REQ-017 The FSM SHALL have states IDLE=0, SERVE=1, PLAY=2, POINT=3, HOLD=4 and OVER=5; codes 6-7 SHALL return to IDLE on the next clock.
REQ-018 start SHALL be registered once, and start_rise SHALL be start AND NOT start_q.
REQ-019 IDLE: score_rst=1, ball_reset=1, ball_en=0; start_rise SHALL clear p1_cnt, p2_cnt and the frame counter, and go to SERVE.
REQ-020 SERVE: ball_reset=1, ball_en=0; the frame counter SHALL increment on each frame_tick; when the count reaches SERVE_FRAMES on a tick, the FSM SHALL clear the counter and go to PLAY.
REQ-021 PLAY: ball_en=1, ball_reset=0.
REQ-022 PLAY transitions: ball_out_l SHALL record a player-2 point and go to POINT; ball_out_r SHALL record a player-1 point and go to POINT.
REQ-023 If ball_out_l and ball_out_r are both high in the same cycle, the left input SHALL win and player 2 scores.
REQ-024 POINT SHALL last exactly one cycle: assert the recorded p1_win or p2_win, increment the matching 4-bit internal counter, set ball_en=0, and go to HOLD.
REQ-025 No counter SHALL exceed WIN_SCORE.
REQ-026 HOLD: ball_reset=1; the FSM SHALL wait until ball_out_l and ball_out_r are both low.
REQ-027 On leaving HOLD, the FSM SHALL go to OVER if either counter equals WIN_SCORE; otherwise it SHALL go to SERVE.
REQ-028 On each HOLD-to-SERVE transition, serve_dir SHALL point toward the player who just lost the point.
REQ-029 OVER: game_over=1, ball_reset=1, ball_en=0, and p1_win/p2_win stay 0.
REQ-030 In OVER, start_rise SHALL go to IDLE; score_rst SHALL then assert for at least one cycle before the next SERVE.
REQ-031 p1_win and p2_win SHALL never be high in the same cycle, and each SHALL be high only in POINT.
REQ-032 All outputs SHALL be registered or decoded from the registered state only, with no combinational path from any input to any output.

Reset
REQ-033 While rst=0 at a clock edge, the FSM SHALL go to IDLE and all of these SHALL clear to 0: p1_cnt, p2_cnt, frame counter, start_q, serve_dir.
REQ-034 Output values in reset: score_rst=1, ball_reset=1, ball_en=0, p1_win=0, p2_win=0, game_over=0, state_o=0.
REQ-035 A reset asserted mid-match, including in POINT, SHALL suppress any pending win pulse.

Configuration
REQ-036 Macro MATCH_CTRL_PAUSE_EN SHALL control a pause feature.
REQ-037 With MATCH_CTRL_PAUSE_EN defined, an input pause (1 bit) SHALL exist.
REQ-038 In PLAY or SERVE, a rising edge of pause SHALL toggle a paused flag.
REQ-039 While paused: ball_en=0, the frame counter holds, ball_out inputs are ignored, and the state is frozen.
REQ-040 The paused flag SHALL clear on reset and on entry to IDLE.
REQ-041 Without MATCH_CTRL_PAUSE_EN, the pause port and its logic SHALL be absent.

Verification
REQ-042 Reset then start pulse, SERVE_FRAMES=3 -> ball_en rises on the clock after the 3rd frame_tick; score_rst=0 from SERVE onward.
REQ-043 In PLAY, ball_out_r held high for 5 cycles -> exactly one p1_win pulse, p1_cnt=1, serve_dir=1, and SERVE re-entered only after ball_out_r falls.
REQ-044 ball_out_l and ball_out_r high together -> one p2_win pulse, no p1_win pulse.
REQ-045 Four player-2 points with WIN_SCORE=4 -> game_over=1 after the 4th HOLD; further ball_out inputs produce no pulses; start_rise -> IDLE with score_rst=1.
REQ-046 rst=0 in the cycle the FSM would enter POINT -> no win pulse, state_o=0, both counters 0.
REQ-047 With MATCH_CTRL_PAUSE_EN: pause edge in PLAY -> ball_en=0 and ball_out_r ignored; second pause edge -> play resumes and the next ball_out_r scores.

Source files
------------

// File: rtl/match_ctrl.sv
// match_ctrl: match sequencing FSM (serve, play, point, hold, game over) for a two-player ball game.
// Optional pause input and logic when MATCH_CTRL_PAUSE_EN is defined.
module match_ctrl #(
  parameter int WIN_SCORE    = 4,
  parameter int SERVE_FRAMES = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       frame_tick,
  input  logic       ball_out_l,
  input  logic       ball_out_r,
`ifdef MATCH_CTRL_PAUSE_EN
  input  logic       pause,
`endif
  output logic       p1_win,
  output logic       p2_win,
  output logic       score_rst,
  output logic       ball_reset,
  output logic       ball_en,
  output logic       serve_dir,
  output logic       game_over,
  output logic [2:0] state_o
);
  typedef enum logic [2:0] {IDLE, SERVE, PLAY, POINT, HOLD, OVER} state_t;
  localparam logic [3:0] WIN = 4'(WIN_SCORE);
  localparam logic [7:0] SF  = 8'(SERVE_FRAMES);
  state_t     state;
  logic       start_q, rec_p1, paused;
  logic [3:0] p1_cnt, p2_cnt;
  logic [7:0] frames;
  logic       start_rise;
  assign start_rise = start && !start_q;
`ifdef MATCH_CTRL_PAUSE_EN
  logic pause_q;
  always_ff @(posedge clk) begin
    if (!rst) begin
      pause_q <= 1'b0;
      paused  <= 1'b0;
    end else begin
      pause_q <= pause;
      if (state == IDLE) paused <= 1'b0;
      else if (pause && !pause_q && (state == PLAY || state == SERVE)) paused <= !paused;
    end
  end
`else
  assign paused = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      start_q   <= 1'b0;
      rec_p1    <= 1'b0;
      p1_cnt    <= '0;
      p2_cnt    <= '0;
      frames    <= '0;
      serve_dir <= 1'b0;
    end else begin
      start_q <= start;
      if (!paused) case (state)
        IDLE: if (start_rise) begin
          p1_cnt <= '0;
          p2_cnt <= '0;
          frames <= '0;
          state  <= SERVE;
        end
        SERVE: if (frame_tick) begin
          if (frames + 8'd1 == SF) begin
            frames <= '0;
            state  <= PLAY;
          end else frames <= frames + 8'd1;
        end
        // left goal line takes priority when both report in the same cycle
        PLAY: if (ball_out_l || ball_out_r) begin
          rec_p1 <= !ball_out_l;
          state  <= POINT;
        end
        POINT: begin
          if (rec_p1 && p1_cnt != WIN) p1_cnt <= p1_cnt + 4'd1;
          if (!rec_p1 && p2_cnt != WIN) p2_cnt <= p2_cnt + 4'd1;
          state <= HOLD;
        end
        // serve toward the loser: a player-1 point serves right, toward player 2
        HOLD: if (!ball_out_l && !ball_out_r) begin
          if (p1_cnt == WIN || p2_cnt == WIN) state <= OVER;
          else begin
            serve_dir <= rec_p1;
            state     <= SERVE;
          end
        end
        OVER: if (start_rise) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
  assign p1_win     = state == POINT && rec_p1;
  assign p2_win     = state == POINT && !rec_p1;
  assign score_rst  = state == IDLE;
  assign ball_reset = !(state == PLAY || state == POINT);
  assign ball_en    = state == PLAY && !paused;
  assign game_over  = state == OVER;
  assign state_o    = state;
endmodule

// File: tb/tb_match_ctrl.sv
// tb_match_ctrl: scoreboard bench for match_ctrl; win pulses checked against a queue of expected points.
module tb_match_ctrl;
  logic clk = 0, rst = 0, start = 0, frame_tick = 0, ball_out_l = 0, ball_out_r = 0;
  logic p1_win, p2_win, score_rst, ball_reset, ball_en, serve_dir, game_over;
  logic [2:0] state_o;
`ifdef MATCH_CTRL_PAUSE_EN
  logic pause = 0;
`endif
  int errors = 0, checks = 0;
  logic [1:0] exp_q[$];
  logic [1:0] exp_w;
  match_ctrl #(.WIN_SCORE(4), .SERVE_FRAMES(3)) dut (
    .clk(clk), .rst(rst), .start(start), .frame_tick(frame_tick),
    .ball_out_l(ball_out_l), .ball_out_r(ball_out_r),
`ifdef MATCH_CTRL_PAUSE_EN
    .pause(pause),
`endif
    .p1_win(p1_win), .p2_win(p2_win), .score_rst(score_rst), .ball_reset(ball_reset),
    .ball_en(ball_en), .serve_dir(serve_dir), .game_over(game_over), .state_o(state_o)
  );
  always #5 clk = ~clk;
  // monitor: every win pulse must match the oldest expected point, {p1,p2}
  always @(negedge clk) if (p1_win || p2_win) begin
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL win_pulse: got p1/p2=%b, required no pulse", {p1_win, p2_win});
    end else begin
      exp_w = exp_q.pop_front();
      if ({p1_win, p2_win} !== exp_w) begin
        errors++;
        $display("FAIL win_pulse: got p1/p2=%b, required %b", {p1_win, p2_win}, exp_w);
      end
    end
  end
  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic press_start();
    start = 1;
    step();
    start = 0;
    step();
  endtask
  task automatic serve();
    repeat (2) begin
      frame_tick = 1;
      step();
      frame_tick = 0;
      step();
    end
    chk("serve_wait_state", 8'(state_o), 8'd1);
    chk("serve_wait_ball_en", 8'(ball_en), 8'd0);
    frame_tick = 1;
    step();
    frame_tick = 0;
    chk("play_state", 8'(state_o), 8'd2);
    chk("play_ball_en", 8'(ball_en), 8'd1);
  endtask
  // score by driving goal lines for hold cycles, then release and take the HOLD exit
  task automatic point(input logic l, input logic r, input int hold, input logic [2:0] next_state);
    exp_q.push_back(l ? 2'b01 : 2'b10);
    ball_out_l = l;
    ball_out_r = r;
    repeat (hold) step();
    chk("hold_state", 8'(state_o), 8'd4);
    ball_out_l = 0;
    ball_out_r = 0;
    step();
    chk("after_hold_state", 8'(state_o), 8'(next_state));
  endtask
  initial begin
    repeat (3) step();
    chk("rst_state", 8'(state_o), 8'd0);
    chk("rst_outs", {2'b0, score_rst, ball_reset, ball_en, p1_win, p2_win, game_over}, 8'b0011_0000);
    chk("rst_serve_dir", 8'(serve_dir), 8'd0);
    rst = 1;
    step();
    press_start();
    chk("serve_state", 8'(state_o), 8'd1);
    chk("serve_outs", {5'b0, score_rst, ball_reset, ball_en}, 8'b010);
    serve();
    point(0, 1, 5, 3'd1);
    chk("serve_dir_p1_point", 8'(serve_dir), 8'd1);
    serve();
    point(1, 1, 2, 3'd1);
    chk("serve_dir_p2_point", 8'(serve_dir), 8'd0);
    serve();
    point(1, 0, 2, 3'd1);
    serve();
    point(1, 0, 3, 3'd1);
    chk("not_over_at_3", 8'(game_over), 8'd0);
    serve();
    point(1, 0, 2, 3'd5);
    chk("game_over", {6'b0, game_over, ball_en}, 8'b10);
    ball_out_r = 1;
    repeat (3) step();
    ball_out_r = 0;
    ball_out_l = 1;
    repeat (2) step();
    ball_out_l = 0;
    chk("over_holds", 8'(state_o), 8'd5);
    start = 1;
    step();
    start = 0;
    chk("idle_after_over", {3'b0, state_o, score_rst, game_over}, {3'b0, 3'd0, 2'b10});
    step();
    press_start();
    serve();
    ball_out_r = 1;
    rst = 0;
    step();
    chk("rst_pre_point_state", 8'(state_o), 8'd0);
    rst = 1;
    ball_out_r = 0;
    step();
    chk("rst_pre_point_idle", 8'(state_o), 8'd0);
    press_start();
    serve();
    point(0, 1, 2, 3'd1);
    chk("serve_dir_after_rst", 8'(serve_dir), 8'd1);
`ifdef MATCH_CTRL_PAUSE_EN
    serve();
    pause = 1;
    step();
    pause = 0;
    chk("paused_ball_en", 8'(ball_en), 8'd0);
    ball_out_r = 1;
    repeat (3) step();
    ball_out_r = 0;
    step();
    chk("paused_state", 8'(state_o), 8'd2);
    pause = 1;
    step();
    pause = 0;
    chk("resumed_ball_en", 8'(ball_en), 8'd1);
    point(0, 1, 2, 3'd1);
`endif
    repeat (2) step();
    chk("pulses_outstanding", 8'(exp_q.size()), 8'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1);
  end
endmodule
